// File: rtl/ppu_cpu_regs_pkg.sv
// ppu_cpu_regs_pkg: shared definitions for the PPU CPU-side register window.
//   - register indices within the folded $2000-$2007 window
//   - $2007 transaction state encoding
//   - default first palette address (reads at or above it are unbuffered)
package ppu_cpu_regs_pkg;

    localparam logic [2:0] REG_CTRL    = 3'd0;  // $2000 PPUCTRL
    localparam logic [2:0] REG_MASK    = 3'd1;  // $2001 PPUMASK
    localparam logic [2:0] REG_STATUS  = 3'd2;  // $2002 PPUSTATUS
    localparam logic [2:0] REG_OAMADDR = 3'd3;  // $2003 OAMADDR
    localparam logic [2:0] REG_OAMDATA = 3'd4;  // $2004 OAMDATA
    localparam logic [2:0] REG_SCROLL  = 3'd5;  // $2005 PPUSCROLL
    localparam logic [2:0] REG_ADDR    = 3'd6;  // $2006 PPUADDR
    localparam logic [2:0] REG_DATA    = 3'd7;  // $2007 PPUDATA

    localparam logic [14:0] PAL_BASE_DEFAULT = 15'h3F00;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WR_WAIT = 2'd1,
        ST_RD_WAIT = 2'd2
    } data_state_e;

endpackage

// File: rtl/ppu_cpu_regs_scroll_regs.sv
// ppu_scroll_regs: the loopy scroll/address latches t, v, fine_x and the
// shared write toggle w.
//   clk, rst_n   clock, asynchronous active-low reset
//   ctrl_wr      $2000 write: t[11:10] <= d[1:0]
//   scroll_wr    $2005 write (first/second half selected by w)
//   addr_wr      $2006 write (second half also copies the new t into v)
//   status_rd    $2002 read: clears w
//   v_inc        $2007 transaction acknowledged: advance v
//   inc32        step size select (1 = +32, 0 = +1)
//   wr_data      CPU write data
//   t, v         temporary and current VRAM address
//   fine_x       fine horizontal scroll
module ppu_scroll_regs
    import ppu_cpu_regs_pkg::*;
#(
    parameter int VADDR_W = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ctrl_wr,
    input  logic               scroll_wr,
    input  logic               addr_wr,
    input  logic               status_rd,
    input  logic               v_inc,
    input  logic               inc32,
    input  logic [7:0]         wr_data,
    output logic [VADDR_W-1:0] t,
    output logic [VADDR_W-1:0] v,
    output logic [2:0]         fine_x
);

    logic [VADDR_W-1:0] t_q, t_d, v_q, v_d;
    logic [2:0]         fine_x_q, fine_x_d;
    logic               w_q, w_d;

    always_comb begin
        // NOTE: every signal gets a default before any condition, otherwise
        // a path that skips an assignment infers a latch.
        t_d      = t_q;
        v_d      = v_q;
        fine_x_d = fine_x_q;
        w_d      = w_q;

        if (v_inc) begin
            v_d = v_q + (inc32 ? VADDR_W'(32) : VADDR_W'(1));
        end

        if (ctrl_wr) begin
            t_d[11:10] = wr_data[1:0];
        end

        if (scroll_wr) begin
            if (!w_q) begin
                t_d[4:0] = wr_data[7:3];
                fine_x_d = wr_data[2:0];
            end else begin
                t_d[14:12] = wr_data[2:0];
                t_d[9:5]   = wr_data[7:3];
            end
            w_d = ~w_q;
        end

        // A $2006 load of v takes precedence over an increment in the same cycle.
        if (addr_wr) begin
            if (!w_q) begin
                t_d[13:8] = wr_data[5:0];
                t_d[14]   = 1'b0;
            end else begin
                t_d[7:0] = wr_data;
                v_d      = t_d;
            end
            w_d = ~w_q;
        end

        if (status_rd) begin
            w_d = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q      <= '0;
            v_q      <= '0;
            fine_x_q <= '0;
            w_q      <= 1'b0;
        end else begin
            t_q      <= t_d;
            v_q      <= v_d;
            fine_x_q <= fine_x_d;
            w_q      <= w_d;
        end
    end

    assign t      = t_q;
    assign v      = v_q;
    assign fine_x = fine_x_q;

endmodule

// File: rtl/ppu_cpu_regs.sv
// ppu_cpu_regs: CPU-side responder for the PPU register window $2000-$2007.
// Holds PPUCTRL/PPUMASK, the vblank flag, OAMADDR, the $2007 read buffer and
// (through ppu_scroll_regs) t/v/fine_x/w; runs VRAM transactions for $2007,
// OAM writes for $2004, and drives the registered active-low NMI.
//   CPU side : reg_sel, reg_addr, reg_wr, reg_rd, wr_data -> rd_data, rd_valid, busy
//   timing   : vblank_set, vblank_clr, spr0_hit, spr_ovf
//   state    : ctrl, mask, vaddr, taddr, fine_x, nmi_n
//   VRAM     : vram_req, vram_we, vram_addr, vram_wdata <- vram_ack, vram_rdata
//   OAM      : oam_addr, oam_we, oam_wdata <- oam_rdata
// Build option PPU_OPEN_BUS_EN: adds an 8-bit open-bus latch (last written or
// read byte) returned in $2002 bits [4:0] and on write-only register reads;
// without it those bits/reads are zero.
module ppu_cpu_regs
    import ppu_cpu_regs_pkg::*;
#(
    parameter int                 VADDR_W  = 15,
    parameter logic [VADDR_W-1:0] PAL_BASE = VADDR_W'(PAL_BASE_DEFAULT)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reg_sel,
    input  logic [2:0]         reg_addr,
    input  logic               reg_wr,
    input  logic               reg_rd,
    input  logic [7:0]         wr_data,
    output logic [7:0]         rd_data,
    output logic               rd_valid,
    output logic               busy,
    input  logic               vblank_set,
    input  logic               vblank_clr,
    input  logic               spr0_hit,
    input  logic               spr_ovf,
    output logic [7:0]         ctrl,
    output logic [7:0]         mask,
    output logic [VADDR_W-1:0] vaddr,
    output logic [VADDR_W-1:0] taddr,
    output logic [2:0]         fine_x,
    output logic               nmi_n,
    output logic               vram_req,
    output logic               vram_we,
    output logic [13:0]        vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic               vram_ack,
    input  logic [7:0]         vram_rdata,
    output logic [7:0]         oam_addr,
    output logic               oam_we,
    output logic [7:0]         oam_wdata,
    input  logic [7:0]         oam_rdata
);

    logic        wr_any, rd_any;
    logic        ctrl_wr, mask_wr, oamaddr_wr, oamdata_wr, scroll_wr, addr_wr;
    logic        status_rd, data_wr, data_rd, data_ack, pal_now;
    logic [7:0]  open_bus;

    data_state_e state_q, state_d;
    logic [7:0]  ctrl_q, ctrl_d, mask_q, mask_d;
    logic [7:0]  oam_addr_q, oam_addr_d, oam_wdata_q, oam_wdata_d;
    logic        oam_we_q, oam_we_d, vblank_q, vblank_d, nmi_n_q, nmi_n_d;
    logic        rd_valid_q, rd_valid_d, pal_q, pal_d;
    logic [7:0]  rd_data_q, rd_data_d, rbuf_q, rbuf_d, vram_wdata_q, vram_wdata_d;
    logic [13:0] vram_addr_q, vram_addr_d;

    // Strobe decode. $2007 accesses count only while no transaction is pending.
    assign wr_any     = reg_sel & reg_wr;
    assign rd_any     = reg_sel & reg_rd;
    assign ctrl_wr    = wr_any && (reg_addr == REG_CTRL);
    assign mask_wr    = wr_any && (reg_addr == REG_MASK);
    assign oamaddr_wr = wr_any && (reg_addr == REG_OAMADDR);
    assign oamdata_wr = wr_any && (reg_addr == REG_OAMDATA);
    assign scroll_wr  = wr_any && (reg_addr == REG_SCROLL);
    assign addr_wr    = wr_any && (reg_addr == REG_ADDR);
    assign status_rd  = rd_any && (reg_addr == REG_STATUS);
    assign data_wr    = wr_any && (reg_addr == REG_DATA) && (state_q == ST_IDLE);
    assign data_rd    = rd_any && (reg_addr == REG_DATA) && (state_q == ST_IDLE);
    assign data_ack   = vram_ack && (state_q != ST_IDLE);
    assign pal_now    = (vaddr >= PAL_BASE);

    ppu_scroll_regs #(.VADDR_W(VADDR_W)) u_scroll (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl_wr   (ctrl_wr),
        .scroll_wr (scroll_wr),
        .addr_wr   (addr_wr),
        .status_rd (status_rd),
        .v_inc     (data_ack),
        .inc32     (ctrl_q[2]),
        .wr_data   (wr_data),
        .t         (taddr),
        .v         (vaddr),
        .fine_x    (fine_x)
    );

    // $2007 FSM: state register / next state / outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (data_wr)      state_d = ST_WR_WAIT;
                else if (data_rd) state_d = ST_RD_WAIT;
            end
            ST_WR_WAIT, ST_RD_WAIT: begin
                if (vram_ack) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Decoded from the state flop, so reset drops the request immediately.
    always_comb begin
        vram_req = 1'b0;
        vram_we  = 1'b0;
        case (state_q)
            ST_WR_WAIT: begin
                vram_req = 1'b1;
                vram_we  = 1'b1;
            end
            ST_RD_WAIT: vram_req = 1'b1;
            default: ;
        endcase
    end

    assign busy = vram_req;

`ifdef PPU_OPEN_BUS_EN
    logic [7:0] open_bus_q, open_bus_d;

    always_comb begin
        open_bus_d = open_bus_q;
        if (wr_any)          open_bus_d = wr_data;
        else if (rd_valid_d) open_bus_d = rd_data_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) open_bus_q <= '0;
        else        open_bus_q <= open_bus_d;
    end

    assign open_bus = open_bus_q;
`else
    assign open_bus = 8'h00;
`endif

    always_comb begin
        ctrl_d       = ctrl_q;
        mask_d       = mask_q;
        oam_addr_d   = oam_addr_q;
        oam_we_d     = 1'b0;
        oam_wdata_d  = oam_wdata_q;
        rd_valid_d   = 1'b0;
        rd_data_d    = rd_data_q;
        rbuf_d       = rbuf_q;
        pal_d        = pal_q;
        vram_addr_d  = vram_addr_q;
        vram_wdata_d = vram_wdata_q;
        nmi_n_d      = ~(vblank_q & ctrl_q[7]);

        // Status read and vblank_clr both beat a coincident vblank_set.
        vblank_d = vblank_q;
        if (vblank_set) vblank_d = 1'b1;
        if (status_rd)  vblank_d = 1'b0;
        if (vblank_clr) vblank_d = 1'b0;

        // The OAM address advances once the write pulse, which presents the
        // pre-increment address, has been issued.
        if (oam_we_q)   oam_addr_d = oam_addr_q + 8'd1;
        if (ctrl_wr)    ctrl_d     = wr_data;
        if (mask_wr)    mask_d     = wr_data;
        if (oamaddr_wr) oam_addr_d = wr_data;
        if (oamdata_wr) begin
            oam_we_d    = 1'b1;
            oam_wdata_d = wr_data;
        end

        if (data_wr || data_rd) begin
            vram_addr_d = vaddr[13:0];
            pal_d       = pal_now;
        end
        if (data_wr) vram_wdata_d = wr_data;

        if (data_ack && (state_q == ST_RD_WAIT)) begin
            rbuf_d = vram_rdata;
            if (pal_q) begin
                rd_valid_d = 1'b1;
                rd_data_d  = vram_rdata;
            end
        end

        // A register read strobe overrides a coincident palette completion.
        if (rd_any) begin
            case (reg_addr)
                REG_STATUS: begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = {vblank_q & ~vblank_set, spr0_hit, spr_ovf, open_bus[4:0]};
                end
                REG_OAMDATA: begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = oam_rdata;
                end
                REG_DATA: begin
                    if (data_rd && !pal_now) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = rbuf_q;
                    end
                end
                default: begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = open_bus;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q       <= '0;
            mask_q       <= '0;
            oam_addr_q   <= '0;
            oam_we_q     <= 1'b0;
            oam_wdata_q  <= '0;
            vblank_q     <= 1'b0;
            nmi_n_q      <= 1'b1;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            rbuf_q       <= '0;
            pal_q        <= 1'b0;
            vram_addr_q  <= '0;
            vram_wdata_q <= '0;
        end else begin
            ctrl_q       <= ctrl_d;
            mask_q       <= mask_d;
            oam_addr_q   <= oam_addr_d;
            oam_we_q     <= oam_we_d;
            oam_wdata_q  <= oam_wdata_d;
            vblank_q     <= vblank_d;
            nmi_n_q      <= nmi_n_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            rbuf_q       <= rbuf_d;
            pal_q        <= pal_d;
            vram_addr_q  <= vram_addr_d;
            vram_wdata_q <= vram_wdata_d;
        end
    end

    assign ctrl       = ctrl_q;
    assign mask       = mask_q;
    assign oam_addr   = oam_addr_q;
    assign oam_we     = oam_we_q;
    assign oam_wdata  = oam_wdata_q;
    assign nmi_n      = nmi_n_q;
    assign rd_valid   = rd_valid_q;
    assign rd_data    = rd_data_q;
    assign vram_addr  = vram_addr_q;
    assign vram_wdata = vram_wdata_q;

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// tb_ppu_cpu_regs: directed bench for ppu_cpu_regs. A cycle-level behavioural
// model of the register window (plain field arithmetic on t/v, a transaction
// flag for $2007) is compared against every visible output each cycle, and
// literal expectations taken from hand calculation pin the model.
module tb_ppu_cpu_regs;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        reg_sel, reg_wr, reg_rd;
    logic [2:0]  reg_addr;
    logic [7:0]  wr_data;
    logic [7:0]  rd_data;
    logic        rd_valid, busy;
    logic        vblank_set, vblank_clr, spr0_hit, spr_ovf;
    logic [7:0]  ctrl, mask;
    logic [14:0] vaddr, taddr;
    logic [2:0]  fine_x;
    logic        nmi_n;
    logic        vram_req, vram_we;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic        vram_ack;
    logic [7:0]  vram_rdata;
    logic [7:0]  oam_addr;
    logic        oam_we;
    logic [7:0]  oam_wdata, oam_rdata;

    always #5 clk = ~clk;

    ppu_cpu_regs dut (
        .clk(clk), .rst_n(rst_n),
        .reg_sel(reg_sel), .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_rd(reg_rd),
        .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
        .vblank_set(vblank_set), .vblank_clr(vblank_clr),
        .spr0_hit(spr0_hit), .spr_ovf(spr_ovf),
        .ctrl(ctrl), .mask(mask), .vaddr(vaddr), .taddr(taddr), .fine_x(fine_x),
        .nmi_n(nmi_n),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
        .vram_wdata(vram_wdata), .vram_ack(vram_ack), .vram_rdata(vram_rdata),
        .oam_addr(oam_addr), .oam_we(oam_we), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_ctrl, m_mask, m_oam_a, m_oam_wdata, m_buf, m_rd_data, m_vwdata;
    logic [14:0] m_t, m_v;
    logic [2:0]  m_fx;
    logic [13:0] m_vaddr;
    bit          m_w, m_vbl, m_nmi_n, m_rd_valid, m_oam_we, m_pal;
    int          m_txn;  // 0 none, 1 VRAM write pending, 2 VRAM read pending

    task automatic model_reset();
        m_ctrl = 0; m_mask = 0; m_oam_a = 0; m_oam_wdata = 0; m_buf = 0;
        m_rd_data = 0; m_vwdata = 0; m_t = 0; m_v = 0; m_fx = 0; m_vaddr = 0;
        m_w = 0; m_vbl = 0; m_nmi_n = 1; m_rd_valid = 0; m_oam_we = 0;
        m_pal = 0; m_txn = 0;
    endtask

    task automatic model_step();
        logic [7:0] o_ctrl;
        bit o_vbl, o_busy, st_rd;
        o_ctrl = m_ctrl;
        o_vbl  = m_vbl;
        o_busy = (m_txn != 0);
        st_rd  = reg_sel && reg_rd && (reg_addr == 3'd2);

        m_nmi_n    = !(o_vbl && o_ctrl[7]);
        m_rd_valid = 0;
        if (m_oam_we) m_oam_a = m_oam_a + 8'd1;
        m_oam_we = 0;
        m_vbl = vblank_clr ? 1'b0 : st_rd ? 1'b0 : vblank_set ? 1'b1 : o_vbl;

        if (o_busy && vram_ack) begin
            if (m_txn == 2) begin
                if (m_pal) begin
                    m_rd_valid = 1;
                    m_rd_data  = vram_rdata;
                end
                m_buf = vram_rdata;
            end
            m_v   = m_v + (o_ctrl[2] ? 15'd32 : 15'd1);
            m_txn = 0;
        end

        if (reg_sel && reg_wr) begin
            case (reg_addr)
                3'd0: begin
                    m_ctrl = wr_data;
                    m_t = (m_t & ~15'h0C00) | (15'(wr_data[1:0]) << 10);
                end
                3'd1: m_mask = wr_data;
                3'd3: m_oam_a = wr_data;
                3'd4: begin m_oam_we = 1; m_oam_wdata = wr_data; end
                3'd5: begin
                    if (!m_w) begin
                        m_t  = (m_t & ~15'h001F) | 15'(wr_data >> 3);
                        m_fx = wr_data[2:0];
                    end else begin
                        m_t = (m_t & ~15'h73E0) | (15'(wr_data[2:0]) << 12) | (15'(wr_data >> 3) << 5);
                    end
                    m_w = !m_w;
                end
                3'd6: begin
                    if (!m_w) begin
                        m_t = (m_t & 15'h00FF) | (15'(wr_data[5:0]) << 8);
                    end else begin
                        m_t = (m_t & 15'h7F00) | 15'(wr_data);
                        m_v = m_t;
                    end
                    m_w = !m_w;
                end
                3'd7: if (!o_busy) begin
                    m_txn = 1; m_vaddr = m_v[13:0]; m_vwdata = wr_data;
                end
                default: ;
            endcase
        end

        if (reg_sel && reg_rd) begin
            case (reg_addr)
                3'd2: begin
                    m_rd_valid = 1;
                    m_rd_data  = {o_vbl && !vblank_set, spr0_hit, spr_ovf, 5'b0};
                    m_w        = 0;
                end
                3'd4: begin m_rd_valid = 1; m_rd_data = oam_rdata; end
                3'd7: if (!o_busy) begin
                    m_txn   = 2;
                    m_vaddr = m_v[13:0];
                    m_pal   = (m_v >= 15'h3F00);
                    if (!m_pal) begin m_rd_valid = 1; m_rd_data = m_buf; end
                end
                default: begin m_rd_valid = 1; m_rd_data = 8'h00; end
            endcase
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // ---------------- per-cycle compare ----------------
    logic [7:0] last_rd = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            check("ctrl", ctrl, m_ctrl);
            check("mask", mask, m_mask);
            check("taddr", taddr, m_t);
            check("vaddr", vaddr, m_v);
            check("fine_x", fine_x, m_fx);
            check("nmi_n", nmi_n, m_nmi_n);
            check("busy", busy, m_txn != 0);
            check("vram_req", vram_req, m_txn != 0);
            check("vram_we", vram_we, m_txn == 1);
            check("oam_we", oam_we, m_oam_we);
            check("oam_addr", oam_addr, m_oam_a);
            check("rd_valid", rd_valid, m_rd_valid);
            if (m_oam_we)   check("oam_wdata", oam_wdata, m_oam_wdata);
            if (m_txn != 0) check("vram_addr", vram_addr, m_vaddr);
            if (m_txn == 1) check("vram_wdata", vram_wdata, m_vwdata);
            if (m_rd_valid) check("rd_data", rd_data, m_rd_data);
            if (rd_valid) last_rd = rd_data;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cpu_wr(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_sel = 1; reg_wr = 1; reg_addr = a; wr_data = d;
        @(negedge clk);
        reg_sel = 0; reg_wr = 0;
    endtask

    task automatic cpu_rd(input logic [2:0] a);
        @(negedge clk);
        reg_sel = 1; reg_rd = 1; reg_addr = a;
        @(negedge clk);
        reg_sel = 0; reg_rd = 0;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic vram_serve(input logic [7:0] data, input int delay);
        for (int i = 0; i < 50; i++) begin
            if (vram_req) break;
            @(negedge clk);
        end
        check("vram_req_seen", vram_req, 1'b1);
        repeat (delay) @(negedge clk);
        vram_ack = 1; vram_rdata = data;
        @(negedge clk);
        vram_ack = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 0; reg_sel = 0; reg_wr = 0; reg_rd = 0; reg_addr = 0; wr_data = 0;
        vblank_set = 0; vblank_clr = 0; spr0_hit = 0; spr_ovf = 0;
        vram_ack = 0; vram_rdata = 0; oam_rdata = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        check("rst_ctrl", ctrl, 8'h00);
        check("rst_nmi_n", nmi_n, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_vaddr", vaddr, 15'h0000);

        // Status after reset.
        cpu_rd(3'd2); settle(1);
        check("status_after_rst", last_rd, 8'h00);
        check("nmi_n_idle", nmi_n, 1'b1);

        // $2006 = $21,$08 then $2007 write of $55; a $2007 read while busy is dropped.
        cpu_wr(3'd6, 8'h21); cpu_wr(3'd6, 8'h08); settle(1);
        check("v_after_2006", vaddr, 15'h2108);
        cpu_wr(3'd7, 8'h55);
        check("wr_vram_addr", vram_addr, 14'h2108);
        check("wr_vram_wdata", vram_wdata, 8'h55);
        cpu_rd(3'd7);
        vram_serve(8'h00, 2); settle(1);
        check("v_after_write", vaddr, 15'h2109);

        // Increment-by-32 buffered reads.
        cpu_wr(3'd0, 8'h04);
        cpu_wr(3'd6, 8'h20); cpu_wr(3'd6, 8'h00);
        cpu_rd(3'd7); settle(1);
        check("buf_read_1", last_rd, 8'h00);
        vram_serve(8'hAA, 1);
        cpu_rd(3'd7); settle(1);
        check("buf_read_2", last_rd, 8'hAA);
        vram_serve(8'hBB, 0); settle(1);
        check("v_after_inc32", vaddr, 15'h2040);

        // Palette read returns data directly.
        cpu_wr(3'd6, 8'h3F); cpu_wr(3'd6, 8'h01);
        cpu_rd(3'd7);
        vram_serve(8'h0F, 1); settle(1);
        check("pal_read", last_rd, 8'h0F);

        // NMI on vblank with ctrl[7]; status read clears flag, NMI and w.
        cpu_wr(3'd0, 8'h80);
        @(negedge clk); vblank_set = 1; @(negedge clk); vblank_set = 0;
        settle(2);
        check("nmi_asserted", nmi_n, 1'b0);
        cpu_wr(3'd5, 8'h00);
        cpu_rd(3'd2); settle(1);
        check("status_vblank", last_rd, 8'h80);
        check("nmi_released", nmi_n, 1'b1);
        cpu_wr(3'd6, 8'h12); cpu_wr(3'd6, 8'h34); settle(1);
        check("w_cleared_v", vaddr, 15'h1234);

        // $2005 field placement.
        cpu_wr(3'd5, 8'h7D); cpu_wr(3'd5, 8'h5E); settle(1);
        check("t_coarse_x", taddr[4:0], 5'h0F);
        check("fine_x_val", fine_x, 3'd5);
        check("t_fine_y", taddr[14:12], 3'd6);
        check("t_coarse_y", taddr[9:5], 5'h0B);

        // Status read coincident with vblank_set: reads 0 and flag stays clear.
        spr0_hit = 1;
        @(negedge clk); reg_sel = 1; reg_rd = 1; reg_addr = 3'd2; vblank_set = 1;
        @(negedge clk); reg_sel = 0; reg_rd = 0; vblank_set = 0;
        settle(1);
        check("race_status", last_rd, 8'h40);
        settle(2);
        check("race_nmi_n", nmi_n, 1'b1);
        @(negedge clk); vblank_set = 1; vblank_clr = 1;
        @(negedge clk); vblank_set = 0; vblank_clr = 0;
        cpu_rd(3'd2); settle(1);
        check("clr_beats_set", last_rd, 8'h40);
        spr0_hit = 0;

        // OAM address wrap and OAMDATA read.
        cpu_wr(3'd3, 8'hFE);
        cpu_wr(3'd4, 8'h11); cpu_wr(3'd4, 8'h22); cpu_wr(3'd4, 8'h33);
        settle(2);
        check("oam_wrap", oam_addr, 8'h01);
        oam_rdata = 8'hC3;
        cpu_rd(3'd4); settle(1);
        check("oam_read", last_rd, 8'hC3);
        check("oam_no_inc", oam_addr, 8'h01);

        // Mask write; write-only register reads as zero.
        cpu_wr(3'd1, 8'h1E);
        check("mask_val", mask, 8'h1E);
        cpu_rd(3'd1); settle(1);
        check("wo_read_zero", last_rd, 8'h00);

        // Reset in the middle of a VRAM write.
        cpu_wr(3'd7, 8'h99);
        check("busy_before_abort", busy, 1'b1);
        #2 rst_n = 0;
        #1;
        check("abort_vram_req", vram_req, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_vaddr", vaddr, 15'h0000);
        @(negedge clk); rst_n = 1;
        settle(2);
        check("post_abort_ctrl", ctrl, 8'h00);

        settle(2);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
